// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the byte-lane data memory: starvation guard, lock FSM,
// round-robin fallback and a registered one-cycle response per port.
package data_mem_arbiter_pkg;
  typedef logic [31:0] word_t;
  typedef logic [3:0]  byte_sel_t;
  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCK0    = 2'd1,
    LOCK1    = 2'd2
  } lock_state_t;
endpackage

// Handshake: a port raises req[x] and holds it until it sees gnt[x] in the same cycle; the
// transfer happens on that edge and rsp_valid[x] pulses for exactly one cycle afterwards.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  lock,
  input  byte_sel_t   p0_wr_sel,
  input  byte_sel_t   p1_wr_sel,
  input  word_t       p0_addr,
  input  word_t       p1_addr,
  input  word_t       p0_wr_data,
  input  word_t       p1_wr_data,
  output logic [1:0]  gnt,
  output logic [1:0]  rsp_valid,
  output word_t       rsp_data,
  output byte_sel_t   mem_wr_sel,
  output word_t       mem_addr,
  output word_t       mem_wr_data,
  input  word_t       mem_rd_data,
  output lock_state_t dbg_state
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  lock_state_t state, state_n;
  logic        last_gnt, last_gnt_n;
  logic [3:0]  wait0, wait0_n, wait1, wait1_n;
  logic [1:0]  gnt_c;

  // Grant is forced low while rst is high so the memory port goes quiet without a clock edge.
  always_comb begin
    gnt_c = 2'b00;
    if (!rst) begin
      if (req[0] && wait0 == MAX_W)        gnt_c = 2'b01;
      else if (req[1] && wait1 == MAX_W)   gnt_c = 2'b10;
      else if (state == LOCK0 && req[0])   gnt_c = 2'b01;
      else if (state == LOCK1 && req[1])   gnt_c = 2'b10;
      else if (req == 2'b11)               gnt_c = last_gnt ? 2'b01 : 2'b10;
      else if (req[0])                     gnt_c = 2'b01;
      else if (req[1])                     gnt_c = 2'b10;
    end
  end

  assign gnt       = gnt_c;
  assign dbg_state = state;

  always_comb begin
    mem_wr_sel  = '0;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (gnt_c[0]) begin
      mem_wr_sel  = p0_wr_sel;
      mem_addr    = p0_addr;
      mem_wr_data = p0_wr_data;
    end else if (gnt_c[1]) begin
      mem_wr_sel  = p1_wr_sel;
      mem_addr    = p1_addr;
      mem_wr_data = p1_wr_data;
    end
  end

  // A lock survives only while its owner keeps getting granted with lock held; any refusal
  // (which can only be a starvation grant to the other port) or dropped req releases it.
  always_comb begin
    state_n = state;
    case (state)
      UNLOCKED: begin
        if (gnt_c[0] && lock[0])      state_n = LOCK0;
        else if (gnt_c[1] && lock[1]) state_n = LOCK1;
      end
      LOCK0: begin
        if (!(gnt_c[0] && lock[0]))   state_n = UNLOCKED;
      end
      LOCK1: begin
        if (!(gnt_c[1] && lock[1]))   state_n = UNLOCKED;
      end
      default: state_n = UNLOCKED;
    endcase
  end

  always_comb begin
    wait0_n    = wait0;
    wait1_n    = wait1;
    last_gnt_n = last_gnt;
    if (!req[0] || gnt_c[0])  wait0_n = 4'd0;
    else if (wait0 != MAX_W)  wait0_n = wait0 + 4'd1;
    if (!req[1] || gnt_c[1])  wait1_n = 4'd0;
    else if (wait1 != MAX_W)  wait1_n = wait1 + 4'd1;
    if (|gnt_c)               last_gnt_n = gnt_c[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= UNLOCKED;
      last_gnt  <= 1'b1;
      wait0     <= 4'd0;
      wait1     <= 4'd0;
      rsp_valid <= 2'b00;
      rsp_data  <= '0;
    end else begin
      state     <= state_n;
      last_gnt  <= last_gnt_n;
      wait0     <= wait0_n;
      wait1     <= wait1_n;
      rsp_valid <= gnt_c;
      if (|gnt_c) rsp_data <= mem_rd_data;
    end
  end

endmodule
